// File: rtl/seg_codes_pkg.sv
// Shared seven-segment pattern, symbol code and anode constants for the
// vending-machine display driver and its readback decoder.
package seg_codes_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned FRAME_W = DIG_W * CODE_W;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_M     = 7'b0101010;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_S     = 7'b1010010;
  localparam logic [SEG_W-1:0] SEG_K     = 7'b0001010;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [CODE_W-1:0] CODE_M     = 4'd10;
  localparam logic [CODE_W-1:0] CODE_A     = 4'd11;
  localparam logic [CODE_W-1:0] CODE_S     = 4'd12;
  localparam logic [CODE_W-1:0] CODE_K     = 4'd13;
  localparam logic [CODE_W-1:0] CODE_ERR   = 4'd14;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'd15;

  localparam logic [DIG_W-1:0] AN_POS0 = 4'b1110;
  localparam logic [DIG_W-1:0] AN_POS1 = 4'b1101;
  localparam logic [DIG_W-1:0] AN_POS2 = 4'b1011;
  localparam logic [DIG_W-1:0] AN_POS3 = 4'b0111;

  // Returns {valid, position}; idle or multi-select anodes are not valid.
  function automatic logic [2:0] an_decode(input logic [DIG_W-1:0] an);
    case (an)
      AN_POS0: return 3'b100;
      AN_POS1: return 3'b101;
      AN_POS2: return 3'b110;
      AN_POS3: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to symbol code lookup; unknown
// patterns map to CODE_ERR and raise invalid_c.
module seg7_pattern_decode
  import seg_codes_pkg::*;
(
  input  logic [SEG_W-1:0]  seg_n,
  output logic [CODE_W-1:0] code_c,
  output logic              invalid_c
);

  always_comb begin
    code_c    = CODE_ERR;
    invalid_c = 1'b0;
    case (seg_n)
      SEG_0:     code_c = 4'd0;
      SEG_1:     code_c = 4'd1;
      SEG_2:     code_c = 4'd2;
      SEG_3:     code_c = 4'd3;
      SEG_4:     code_c = 4'd4;
      SEG_5:     code_c = 4'd5;
      SEG_6:     code_c = 4'd6;
      SEG_7:     code_c = 4'd7;
      SEG_8:     code_c = 4'd8;
      SEG_9:     code_c = 4'd9;
      SEG_M:     code_c = CODE_M;
      SEG_A:     code_c = CODE_A;
      SEG_S:     code_c = CODE_S;
      SEG_K:     code_c = CODE_K;
      SEG_BLANK: code_c = CODE_BLANK;
      default:   invalid_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs the four symbols shown on a multiplexed seven-segment display
// from its anode/segment lines and publishes them as atomic frames.
module seg_scan_decoder
  import seg_codes_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65536,
  parameter int unsigned ERR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIG_W-1:0]   digit_n,
  input  logic [SEG_W-1:0]   seg_n,
  output logic [FRAME_W-1:0] code,
  output logic               frame_valid,
  output logic               frame_pulse,
  output logic               frame_changed,
  output logic               err_pattern,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               scan_timeout
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [DIG_W-1:0]   dig_s1, dig_s2;
  logic [SEG_W-1:0]   seg_s1, seg_s2;
  logic [SW-1:0]      stab_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic [DIG_W-1:0]   mask;
  logic [FRAME_W-1:0] shadow;

  logic               stable_c;
  logic               capture_c;
  logic               an_ok_c;
  logic [1:0]         pos_c;
  logic [CODE_W-1:0]  dec_code_c;
  logic               dec_invalid_c;

  // Two-flop synchronizers; reset to an idle, blank display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_s1 <= '1;
      dig_s2 <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
    end else begin
      dig_s1 <= digit_n;
      dig_s2 <= dig_s1;
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
    end
  end

  // dig_s1/seg_s1 are next cycle's synced values, so the counter clears on
  // the same edge the synced value changes
  assign stable_c = (dig_s1 == dig_s2) && (seg_s1 == seg_s2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (!stable_c) begin
      stab_cnt <= '0;
    end else if (stab_cnt != SW'(SETTLE)) begin
      stab_cnt <= stab_cnt + SW'(1);
    end
  end

  assign {an_ok_c, pos_c} = an_decode(dig_s2);
  assign capture_c = stable_c && (stab_cnt == SW'(SETTLE - 1)) && an_ok_c;

  seg7_pattern_decode u_decode (
    .seg_n     (seg_s2),
    .code_c    (dec_code_c),
    .invalid_c (dec_invalid_c)
  );

  // Shadow capture, error accounting, scan timeout and frame publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow        <= '1;
      mask          <= '0;
      code          <= '1;
      frame_valid   <= 1'b0;
      frame_pulse   <= 1'b0;
      frame_changed <= 1'b0;
      err_pattern   <= 1'b0;
      err_cnt       <= '0;
      tmo_cnt       <= '0;
      scan_timeout  <= 1'b0;
    end else begin
      err_pattern   <= 1'b0;
      frame_pulse   <= 1'b0;
      frame_changed <= 1'b0;
      if (capture_c) begin
        shadow[{pos_c, 2'b00} +: CODE_W] <= dec_code_c;
        mask[pos_c]  <= 1'b1;
        err_pattern  <= dec_invalid_c;
        if (dec_invalid_c && (err_cnt != {ERR_W{1'b1}})) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
        tmo_cnt      <= '0;
        scan_timeout <= 1'b0;
      end else if (tmo_cnt != TW'(TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          scan_timeout <= 1'b1;
          frame_valid  <= 1'b0;
          mask         <= '0;
        end
      end
      // Captures are at least two cycles apart, so a full mask never
      // coincides with a new capture
      if (mask == {DIG_W{1'b1}}) begin
        code          <= shadow;
        frame_pulse   <= 1'b1;
        frame_valid   <= 1'b1;
        frame_changed <= (shadow != code);
        mask          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed vector table, hand-written
// corner-case sequences and randomized scans against a dwell-level model.
module tb_seg_scan_decoder;

  localparam int TMO = 2000;

  logic        clk;
  logic        rst;
  logic [3:0]  digit_n;
  logic [6:0]  seg_n;
  logic [15:0] code;
  logic        frame_valid, frame_pulse, frame_changed, err_pattern, scan_timeout;
  logic [7:0]  err_cnt;

  seg_scan_decoder #(.SETTLE(4), .TIMEOUT(TMO), .ERR_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .digit_n       (digit_n),
    .seg_n         (seg_n),
    .code          (code),
    .frame_valid   (frame_valid),
    .frame_pulse   (frame_pulse),
    .frame_changed (frame_changed),
    .err_pattern   (err_pattern),
    .err_cnt       (err_cnt),
    .scan_timeout  (scan_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int errp_cnt = 0;
  int last_pulse_cyc = 0;
  logic last_changed = 1'b0;

  typedef struct { logic [15:0] code; logic changed; } exp_frame_t;
  exp_frame_t exp_q[$];
  exp_frame_t ef;
  logic sb_en = 1'b0;

  // Reference symbol table indexed by code; slot 14 has no pattern
  logic [6:0] ref_seg [16];

  typedef struct { logic [6:0] seg; logic [3:0] nib; logic err; } vec_t;
  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] s, output logic [3:0] nib, output logic inv);
    nib = 4'd14;
    inv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i != 14 && ref_seg[i] == s) begin
        nib = 4'(i);
        inv = 1'b0;
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor and frame scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_pulse) begin
        pulse_cnt++;
        last_pulse_cyc = cyc;
        last_changed = frame_changed;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_frame", 32'd1, 32'd0);
          end else begin
            ef = exp_q.pop_front();
            chk("sb_code", 32'(code), 32'(ef.code));
            chk("sb_changed", 32'(frame_changed), 32'(ef.changed));
          end
        end
      end
      if (err_pattern) errp_cnt++;
      chk("changed_without_pulse", 32'(frame_changed & ~frame_pulse), 32'd0);
    end
  end

  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
    digit_n = d;
    seg_n = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input int n);
    drive(4'b1110, s0, n);
    drive(4'b1101, s1, n);
    drive(4'b1011, s2, n);
    drive(4'b0111, s3, n);
  endtask

  task automatic do_reset();
    digit_n = 4'hF;
    seg_n = 7'h7F;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int p0, e0, t4, budget, m_errs, len, pos, idx;
  logic [3:0] d, pd, m_mask, nib;
  logic [6:0] s, ps;
  logic inv;
  logic [3:0] m_sh [4];
  logic [15:0] m_last;
  exp_frame_t nf;

  initial begin
    ref_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h2A, 7'h20, 7'h52, 7'h0A, 7'h3F, 7'h7F};
    tbl[0]  = '{7'h40, 4'd0,  1'b0};  tbl[1]  = '{7'h79, 4'd1,  1'b0};
    tbl[2]  = '{7'h24, 4'd2,  1'b0};  tbl[3]  = '{7'h30, 4'd3,  1'b0};
    tbl[4]  = '{7'h19, 4'd4,  1'b0};  tbl[5]  = '{7'h12, 4'd5,  1'b0};
    tbl[6]  = '{7'h02, 4'd6,  1'b0};  tbl[7]  = '{7'h78, 4'd7,  1'b0};
    tbl[8]  = '{7'h00, 4'd8,  1'b0};  tbl[9]  = '{7'h10, 4'd9,  1'b0};
    tbl[10] = '{7'h2A, 4'd10, 1'b0};  tbl[11] = '{7'h20, 4'd11, 1'b0};
    tbl[12] = '{7'h52, 4'd12, 1'b0};  tbl[13] = '{7'h0A, 4'd13, 1'b0};
    tbl[14] = '{7'h7F, 4'd15, 1'b0};  tbl[15] = '{7'h3F, 4'd14, 1'b1};
    tbl[16] = '{7'h7E, 4'd14, 1'b1};  tbl[17] = '{7'h01, 4'd14, 1'b1};
    tbl[18] = '{7'h41, 4'd14, 1'b1};  tbl[19] = '{7'h11, 4'd14, 1'b1};

    digit_n = 4'hF;
    seg_n = 7'h7F;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_code", 32'(code), 32'hFFFF);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_pulse", 32'(frame_pulse), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_timeout", 32'(scan_timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two identical rounds of 0,5,3,0
    p0 = pulse_cnt;
    drive_frame(7'h40, 7'h12, 7'h30, 7'h40, 100);
    chk("round1_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("round1_code", 32'(code), 32'h0350);
    chk("round1_changed", 32'(last_changed), 32'd1);
    chk("round1_valid", 32'(frame_valid), 32'd1);
    p0 = pulse_cnt;
    drive_frame(7'h40, 7'h12, 7'h30, 7'h40, 100);
    chk("round2_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("round2_code", 32'(code), 32'h0350);
    chk("round2_changed", 32'(last_changed), 32'd0);

    // K,S,A,M on pos0..pos3, with latency measured from the last dwell start
    drive(4'b1110, 7'h0A, 10);
    drive(4'b1101, 7'h52, 10);
    drive(4'b1011, 7'h20, 10);
    t4 = cyc;
    drive(4'b0111, 7'h2A, 10);
    chk("ksam_code", 32'(code), 32'hABCD);
    chk("ksam_errcnt", 32'(err_cnt), 32'd0);
    chk("ksam_latency_ok", 32'((last_pulse_cyc - t4) <= 7), 32'd1);

    // Undecodable pattern on pos2, then saturation of the error counter
    e0 = errp_cnt;
    drive_frame(7'h40, 7'h79, 7'h3F, 7'h24, 10);
    chk("err_code", 32'(code), 32'h2E10);
    chk("err_pulses", 32'(errp_cnt - e0), 32'd1);
    chk("err_cnt_1", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 300; i++) begin
      drive(4'b1011, 7'h3F, 7);
      drive(4'hF, 7'h7F, 3);
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Glitching segments on pos0 must not capture until they settle
    drive(4'b1101, 7'h79, 10);
    drive(4'b1011, 7'h24, 10);
    drive(4'b0111, 7'h30, 10);
    p0 = pulse_cnt;
    for (int i = 0; i < 25; i++) begin
      drive(4'b1110, 7'h40, 1);
      drive(4'b1110, 7'h79, 1);
    end
    chk("glitch_no_capture", 32'(pulse_cnt - p0), 32'd0);
    drive(4'b1110, 7'h10, 20);
    chk("glitch_one_capture", 32'(pulse_cnt - p0), 32'd1);
    chk("glitch_code", 32'(code), 32'h3219);

    // Scan stops: timeout exactly TMO cycles after the last capture
    drive(4'hF, 7'h7F, 1);
    budget = TMO + 100;
    while (!scan_timeout && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("timeout_seen", 32'(scan_timeout), 32'd1);
    chk("timeout_delay", 32'(cyc - last_pulse_cyc), 32'(TMO - 1));
    chk("timeout_valid", 32'(frame_valid), 32'd0);
    chk("timeout_code", 32'(code), 32'h3219);
    repeat (50) @(negedge clk);
    chk("timeout_level", 32'(scan_timeout), 32'd1);
    drive(4'b1110, 7'h19, 10);
    chk("resume_timeout_clr", 32'(scan_timeout), 32'd0);
    chk("resume_valid_low", 32'(frame_valid), 32'd0);
    drive(4'b1101, 7'h12, 10);
    drive(4'b1011, 7'h02, 10);
    drive(4'b0111, 7'h78, 10);
    chk("resume_valid", 32'(frame_valid), 32'd1);
    chk("resume_code", 32'(code), 32'h7654);

    // Decode table, one symbol on pos0 with the rest blank
    foreach (tbl[i]) begin
      p0 = pulse_cnt;
      e0 = errp_cnt;
      drive_frame(tbl[i].seg, 7'h7F, 7'h7F, 7'h7F, 10);
      chk($sformatf("tbl%0d_code", i), 32'(code), 32'({12'hFFF, tbl[i].nib}));
      chk($sformatf("tbl%0d_pulse", i), 32'(pulse_cnt - p0), 32'd1);
      chk($sformatf("tbl%0d_err", i), 32'(errp_cnt - e0), 32'(tbl[i].err));
    end

    // Reset after two positions captured
    drive(4'b1110, 7'h79, 10);
    drive(4'b1101, 7'h24, 10);
    #3 rst = 1'b1;
    #1;
    chk("midrst_code", 32'(code), 32'hFFFF);
    chk("midrst_valid", 32'(frame_valid), 32'd0);
    digit_n = 4'hF;
    seg_n = 7'h7F;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pulse_cnt;
    drive(4'b1011, 7'h30, 10);
    drive(4'b0111, 7'h19, 10);
    chk("midrst_mask_cleared", 32'(pulse_cnt - p0), 32'd0);
    drive(4'b1110, 7'h12, 10);
    drive(4'b1101, 7'h02, 10);
    chk("midrst_pulse", 32'(pulse_cnt - p0), 32'd1);
    chk("midrst_frame", 32'(code), 32'h4365);
    chk("midrst_changed", 32'(last_changed), 32'd1);

    // Randomized dwells against the dwell-level model
    do_reset();
    sb_en = 1'b1;
    e0 = errp_cnt;
    m_errs = 0;
    m_mask = 4'h0;
    m_last = 16'hFFFF;
    for (int i = 0; i < 4; i++) m_sh[i] = 4'hF;
    pd = 4'hF;
    ps = 7'h7F;
    for (int n = 0; n < 200; n++) begin
      do begin
        case ($urandom_range(0, 9))
          8: d = 4'hF;
          9: d = 4'($urandom);
          default: d = 4'hF ^ (4'(1) << $urandom_range(0, 3));
        endcase
        if ($urandom_range(0, 3) != 0) begin
          do idx = $urandom_range(0, 15); while (idx == 14);
          s = ref_seg[idx];
        end else begin
          s = 7'($urandom);
        end
      end while (d == pd && s == ps);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 3) : $urandom_range(6, 12);
      pos = -1;
      for (int p = 0; p < 4; p++) if (d == (4'hF ^ (4'(1) << p))) pos = p;
      if (len >= 6 && pos >= 0) begin
        ref_decode(s, nib, inv);
        m_sh[pos] = nib;
        m_mask[pos] = 1'b1;
        if (inv) m_errs++;
        if (m_mask == 4'hF) begin
          nf.code = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
          nf.changed = (nf.code != m_last);
          exp_q.push_back(nf);
          m_last = nf.code;
          m_mask = 4'h0;
        end
      end
      drive(d, s, len);
      pd = d;
      ps = s;
    end
    drive(4'hF, 7'h7F, 10);
    sb_en = 1'b0;
    chk("rand_frames_left", 32'(exp_q.size()), 32'd0);
    chk("rand_err_pulses", 32'(errp_cnt - e0), 32'(m_errs));
    chk("rand_err_cnt", 32'(err_cnt), 32'((m_errs > 255) ? 255 : m_errs));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the vending-machine 4-digit multiplexed seven-segment driver.
- Watches the active-low anode-select and segment lines and reconstructs the four displayed symbol codes (0-9, M, A, S, K, blank).
- Publishes complete frames atomically, with pattern-error and scan-timeout monitoring.
- Used as an on-board self-check and readback path: it reports what the display shows, independent of the driver's internal registers.

Parameters:
- SETTLE, 4: consecutive clk cycles that anode and segment inputs must hold steady before a capture.
- TIMEOUT, 65536: clk cycles without any capture before scan_timeout asserts.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- digit_n  in  4  anode select, active-low, one-hot-low when valid.
- seg_n  in  7  segments, active-low; bit6=g ... bit0=a.
- code  out  16  last complete frame, {pos3,pos2,pos1,pos0}, 4 bits per position.
- frame_valid  out  1  code holds a complete, non-stale frame.
- frame_pulse  out  1  one-cycle strobe when code updates.
- frame_changed  out  1  qualified by frame_pulse; new frame differs from the previous one.
- err_pattern  out  1  one-cycle strobe when an undecodable pattern is captured.
- err_cnt  out  ERR_W  saturating count of err_pattern strobes.
- scan_timeout  out  1  level; no capture for TIMEOUT cycles.

Behaviour:
- Reset values:
  - code = 16'hFFFF (all blank).
  - frame_valid, frame_pulse, frame_changed, err_pattern, scan_timeout = 0.
  - err_cnt = 0.
  - Partial-frame mask, stability counter and timeout counter cleared.
- Input sync: digit_n and seg_n pass through 2-flop synchronizers. All following logic uses the synced values.
- Stability: counter resets to 0 whenever either synced value differs from its previous-cycle value; otherwise it increments, saturating at SETTLE.
- Capture: occurs in the single cycle in which the counter transitions to SETTLE, and only if digit_n is exactly one of 1110/1101/1011/0111. That position is pos0/pos1/pos2/pos3 respectively.
  - Exactly one capture per dwell: no recapture until the inputs change.
  - digit_n 1111 or multi-low: no capture, no error.
- Decode table (seg_n -> code):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4.
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
  - 0101010->10 (M), 0100000->11 (A), 1010010->12 (S), 0001010->13 (K).
  - 1111111->15 (blank).
  - Anything else -> 14, err_pattern=1 for that cycle, err_cnt+1 saturating at all-ones.
- Capture writes the shadow register for its position and sets that bit of the 4-bit mask.
- Frame completion:
  - When a capture makes the mask 1111, on the next edge: code <= shadow (including the just-captured value), frame_pulse=1, frame_valid=1, frame_changed = (new code != old code), mask <= 0000.
  - Positions may arrive in any order. A repeated position overwrites its shadow without completing the frame.
- Latency: a symbol stable at the pins appears on code no later than 2 + SETTLE + 1 cycles after the fourth position's dwell begins.
- Timeout:
  - Counter increments every cycle and clears on any capture.
  - On reaching TIMEOUT: scan_timeout=1, frame_valid=0, mask cleared; code holds its value. The counter holds at TIMEOUT.
  - The next capture clears scan_timeout. frame_valid returns only on the next complete frame.
- Simultaneous events:
  - Capture and timeout in the same cycle: capture wins, no timeout.
  - Frame completion in the same cycle as err_pattern: the frame still publishes, with code 14 in that position.
- Reset mid-frame: shadow, mask and code return to their reset values immediately (asynchronous).
- frame_changed is 0 whenever frame_pulse is 0.

Decomposition:
- Package seg_codes_pkg:
  - Segment pattern constants SEG_0..SEG_9, SEG_M, SEG_A, SEG_S, SEG_K, SEG_BLANK.
  - Code constants CODE_M=10, CODE_A=11, CODE_S=12, CODE_K=13, CODE_ERR=14, CODE_BLANK=15.
  - Anode constants AN_POS0..AN_POS3.
- Sub-module seg7_pattern_decode: combinational seg_n[6:0] -> {invalid, code[3:0]}. Reusable by the driver's testbench.
- Top level holds the synchronizers, stability counter, shadow/mask, frame register and timeout counter.

Test Plan:
- Drive digit_n 1110/1101/1011/0111 with 0,5,3,0 patterns, 100 cycles each, two rounds -> code=16'h0350 after the first round, frame_pulse once per round, frame_changed=1 then 0.
- Scan K,S,A,M on pos0..pos3 -> code=16'hABCD, err_cnt=0.
- Pos2 pattern 0111111 -> pos2 nibble 14, err_pattern one pulse, err_cnt=1; 300 such captures -> err_cnt=255.
- Glitch: segments toggle every 2 cycles for 50 cycles then hold -> exactly one capture after SETTLE stable cycles; no intermediate code.
- Stop scanning (digit_n=1111) after a valid frame -> scan_timeout=1 exactly TIMEOUT cycles after the last capture, frame_valid=0, code unchanged; resume scanning -> scan_timeout=0 at the first capture, frame_valid=1 after a full frame.
- Assert rst after 2 of 4 positions captured -> code=16'hFFFF, mask cleared; the next full frame publishes normally.
